// File: rtl/alu_ctrl_pkg.sv
// ALU control shared definitions: main-control classes, R-type funct
// codes, decoded ALU op codes and the sequencer state encoding.
package alu_ctrl_pkg;

  localparam logic [2:0] A_ADDI = 3'b000;
  localparam logic [2:0] A_BEQZ = 3'b001;
  localparam logic [2:0] A_LW   = 3'b010;
  localparam logic [2:0] A_SW   = 3'b011;
  localparam logic [2:0] A_DEC  = 3'b100;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SEQ  = 6'h28;
  localparam logic [5:0] F_SLE  = 6'h2C;
  localparam logic [5:0] F_SLL  = 6'h04;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SNE  = 6'h29;
  localparam logic [5:0] F_SRA  = 6'h07;
  localparam logic [5:0] F_SRL  = 6'h06;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_MUL  = 6'h0E;
  localparam logic [5:0] F_DIV  = 6'h0F;

  localparam logic [5:0] D_BEQZ  = 6'h00;
  localparam logic [5:0] D_ADDI  = 6'h08;
  localparam logic [5:0] D_LW    = 6'h23;
  localparam logic [5:0] D_SW    = 6'h2B;
  localparam logic [5:0] D_ADD   = 6'h08;
  localparam logic [5:0] D_AND   = 6'h0C;
  localparam logic [5:0] D_OR    = 6'h0D;
  localparam logic [5:0] D_SEQ   = 6'h18;
  localparam logic [5:0] D_SLE   = 6'h1C;
  localparam logic [5:0] D_SLL   = 6'h14;
  localparam logic [5:0] D_SLT   = 6'h1A;
  localparam logic [5:0] D_SNE   = 6'h19;
  localparam logic [5:0] D_SRA   = 6'h17;
  localparam logic [5:0] D_SRL   = 6'h16;
  localparam logic [5:0] D_SUB   = 6'h0A;
  localparam logic [5:0] D_XOR   = 6'h0E;
  localparam logic [5:0] D_MUL   = 6'h3E;
  localparam logic [5:0] D_DIV   = 6'h3F;
  localparam logic [5:0] D_ILL_A = 6'h00;
  localparam logic [5:0] D_ILL_R = 6'h0E;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control table.
// In: alu_op, opcode, funct. Out: dec_op, illegal, is_multi.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [2:0]      alu_op,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  output logic [OP_W-1:0] dec_op,
  output logic            illegal,
  output logic            is_multi
);

  always_comb begin
    dec_op   = '0;
    illegal  = 1'b0;
    is_multi = 1'b0;
    unique case (alu_op)
      A_ADDI: dec_op = OP_W'(D_ADDI);
      A_BEQZ: dec_op = OP_W'(D_BEQZ);
      A_LW:   dec_op = OP_W'(D_LW);
      A_SW:   dec_op = OP_W'(D_SW);
      A_DEC: begin
        if (opcode != '0) begin
          dec_op = opcode;
        end else begin
          case (funct)
            OP_W'(F_ADD): dec_op = OP_W'(D_ADD);
            OP_W'(F_AND): dec_op = OP_W'(D_AND);
            OP_W'(F_OR):  dec_op = OP_W'(D_OR);
            OP_W'(F_SEQ): dec_op = OP_W'(D_SEQ);
            OP_W'(F_SLE): dec_op = OP_W'(D_SLE);
            OP_W'(F_SLL): dec_op = OP_W'(D_SLL);
            OP_W'(F_SLT): dec_op = OP_W'(D_SLT);
            OP_W'(F_SNE): dec_op = OP_W'(D_SNE);
            OP_W'(F_SRA): dec_op = OP_W'(D_SRA);
            OP_W'(F_SRL): dec_op = OP_W'(D_SRL);
            OP_W'(F_SUB): dec_op = OP_W'(D_SUB);
            OP_W'(F_XOR): dec_op = OP_W'(D_XOR);
            OP_W'(F_MUL): begin
              dec_op   = OP_W'(D_MUL);
              is_multi = 1'b1;
            end
            OP_W'(F_DIV): begin
              dec_op   = OP_W'(D_DIV);
              is_multi = 1'b1;
            end
            default: begin
              dec_op  = OP_W'(D_ILL_R);
              illegal = 1'b1;
            end
          endcase
        end
      end
      default: begin
        dec_op  = OP_W'(D_ILL_A);
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: valid/ready wrapper around the decode table,
// with an IDLE/BUSY FSM that stretches MUL/DIV to their latencies.
// In: clk, rst, flush, in_valid, alu_op, opcode, funct, out_ready.
// Out: in_ready, out_valid, dec_op, illegal, mc_busy.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] dec_op,
  output logic            illegal,
  output logic            mc_busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0] mc_op;

  logic [OP_W-1:0] d_op;
  logic            d_ill;
  logic            d_multi;
  logic            accept;

  alu_ctrl_decode #(.OP_W(OP_W)) u_dec (
    .alu_op   (alu_op),
    .opcode   (opcode),
    .funct    (funct),
    .dec_op   (d_op),
    .illegal  (d_ill),
    .is_multi (d_multi)
  );

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mc_op     <= '0;
      out_valid <= 1'b0;
      dec_op    <= '0;
      illegal   <= 1'b0;
      mc_busy   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      mc_busy   <= 1'b0;
    end else begin
      // a same-cycle single-cycle accept below overrides this clear
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && d_multi) begin
            state   <= BUSY;
            mc_op   <= d_op;
            mc_busy <= 1'b1;
            cnt     <= (d_op == OP_W'(D_MUL)) ? CNT_W'(MUL_LAT - 1)
                                              : CNT_W'(DIV_LAT - 1);
          end else if (accept) begin
            out_valid <= 1'b1;
            dec_op    <= d_op;
            illegal   <= d_ill;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state     <= IDLE;
            mc_busy   <= 1'b0;
            out_valid <= 1'b1;
            dec_op    <= mc_op;
            illegal   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Testbench for alu_ctrl_seq: scoreboard of expected {illegal, dec_op}
// pushed at request time and popped when a result is consumed.
module tb_alu_ctrl_seq;

  localparam int OP_W = 6;
  localparam int NV   = 22;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [2:0]      alu_op = '0;
  logic [OP_W-1:0] opcode = '0;
  logic [OP_W-1:0] funct = '0;
  logic            in_ready;
  logic            out_valid;
  logic [OP_W-1:0] dec_op;
  logic            illegal;
  logic            mc_busy;

  int checks = 0;
  int failures = 0;
  logic [OP_W:0] exp_q[$];
  logic [OP_W:0] exp;

  int v_alu [NV] = '{0, 1, 2, 3, 5, 6, 7, 4, 4,
                     4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
  int v_opc [NV] = '{0, 0, 0, 0, 0, 0, 0, 'h23, 'h3F,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int v_fn  [NV] = '{'h0E, 'h0F, 'h0E, 'h0F, 'h0E, 'h0F, 'h20, 'h0E, 'h0F,
                     'h20, 'h24, 'h25, 'h28, 'h2C, 'h04, 'h2A, 'h29,
                     'h07, 'h06, 'h22, 'h26, 'h3F};
  int v_op  [NV] = '{'h08, 'h00, 'h23, 'h2B, 'h00, 'h00, 'h00, 'h23, 'h3F,
                     'h08, 'h0C, 'h0D, 'h18, 'h1C, 'h14, 'h1A, 'h19,
                     'h17, 'h16, 'h0A, 'h0E, 'h0E};
  int v_ill [NV] = '{0, 0, 0, 0, 1, 1, 1, 0, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  alu_ctrl_seq #(.OP_W(OP_W), .MUL_LAT(4), .DIV_LAT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .opcode    (opcode),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dec_op    (dec_op),
    .illegal   (illegal),
    .mc_busy   (mc_busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, illegal, mc_busy, dec_op} !== '0) begin
      failures++;
      $display("FAIL reset_state got v=%b ill=%b busy=%b op=%h want all 0",
               out_valid, illegal, mc_busy, dec_op);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_classes();
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL class_ready[%0d] got %b want 1", i, in_ready);
      end
      in_valid = 1'b1;
      alu_op   = 3'(v_alu[i]);
      opcode   = OP_W'(v_opc[i]);
      funct    = OP_W'(v_fn[i]);
      exp_q.push_back({1'(v_ill[i]), OP_W'(v_op[i])});
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {illegal, dec_op} !== exp) begin
        failures++;
        $display("FAIL class[%0d] got v=%b ill=%b op=%h want v=1 ill=%b op=%h",
                 i, out_valid, illegal, dec_op, exp[OP_W], exp[OP_W-1:0]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL class_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_multi();
    int cyc;
    int busy;
    int rdy_bad;
    int lat;
    out_ready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      lat = (m == 0) ? 4 : 8;
      in_valid = 1'b1;
      alu_op   = 3'b100;
      opcode   = '0;
      funct    = (m == 0) ? OP_W'('h0E) : OP_W'('h0F);
      exp_q.push_back({1'b0, (m == 0) ? OP_W'('h3E) : OP_W'('h3F)});
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      busy = 0;
      rdy_bad = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
        if (mc_busy === 1'b1) busy++;
        if (in_ready !== 1'b0) rdy_bad++;
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc != lat || busy != lat || rdy_bad != 0) begin
        failures++;
        $display("FAIL multi_lat[%0d] got lat=%0d busy=%0d rdy=%0d want %0d/%0d/0",
                 m, cyc, busy, rdy_bad, lat, lat);
      end
      exp = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || mc_busy !== 1'b0 ||
          {illegal, dec_op} !== exp) begin
        failures++;
        $display("FAIL multi_res[%0d] got v=%b busy=%b ill=%b op=%h want 1/0/%b/%h",
                 m, out_valid, mc_busy, illegal, dec_op, exp[OP_W], exp[OP_W-1:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_op    = 3'b100;
    opcode    = '0;
    funct     = OP_W'('h22);
    exp_q.push_back({1'b0, OP_W'('h0A)});
    @(negedge clk);
    in_valid = 1'b1;
    funct    = OP_W'('h24);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (out_valid !== 1'b1 || dec_op !== OP_W'('h0A) ||
          illegal !== 1'b0 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold got %0d bad cycles want 0 (v=%b op=%h rdy=%b)",
               bad, out_valid, dec_op, in_ready);
    end
    funct     = OP_W'('h20);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready got %b want 1", in_ready);
    end
    exp = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {illegal, dec_op} !== exp) begin
      failures++;
      $display("FAIL b2b_first got v=%b op=%h want v=1 op=%h",
               out_valid, dec_op, exp[OP_W-1:0]);
    end
    exp_q.push_back({1'b0, OP_W'('h08)});
    @(negedge clk);
    in_valid = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {illegal, dec_op} !== exp) begin
      failures++;
      $display("FAIL b2b_second got v=%b op=%h want v=1 op=%h",
               out_valid, dec_op, exp[OP_W-1:0]);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush_div();
    int seen;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_op    = 3'b100;
    opcode    = '0;
    funct     = OP_W'('h0F);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready_low got %b want 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (mc_busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_div got busy=%b v=%b rdy=%b want 0/0/1",
               mc_busy, out_valid, in_ready);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush_no_out got %0d valid cycles want 0", seen);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_op    = 3'b000;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_held got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_rst_div();
    int seen;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_op    = 3'b100;
    opcode    = '0;
    funct     = OP_W'('h0F);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (mc_busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_div_async got busy=%b v=%b want 0/0", mc_busy, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_div_ready got %b want 1", in_ready);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL rst_no_out got %0d valid cycles want 0", seen);
    end
    in_valid = 1'b1;
    alu_op   = 3'b011;
    exp_q.push_back({1'b0, OP_W'('h2B)});
    @(negedge clk);
    in_valid = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {illegal, dec_op} !== exp) begin
      failures++;
      $display("FAIL rst_after got v=%b op=%h want v=1 op=%h",
               out_valid, dec_op, exp[OP_W-1:0]);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_classes();
    test_multi();
    test_back_to_back();
    test_flush_div();
    test_rst_div();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 Parameter OP_W, default 6: opcode/funct/decoded-op width; SHALL be >= 6, and codes SHALL be zero-extended to OP_W.
REQ-002 Parameter MUL_LAT, default 4: MUL latency in cycles; SHALL be >= 2.
REQ-003 Parameter DIV_LAT, default 8: DIV latency in cycles; SHALL be >= 2.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 flush  in  1  synchronous cancel of in-flight and held results.
REQ-007 in_valid  in  1  request valid.
REQ-008 in_ready  out  1  block can accept a request this cycle.
REQ-009 alu_op  in  3  main-control class.
REQ-010 opcode  in  OP_W  instruction bits 31:26, zero-extended.
REQ-011 funct  in  OP_W  instruction bits 5:0, zero-extended.
REQ-012 out_valid  out  1  dec_op/illegal valid.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 dec_op  out  OP_W  decoded ALU operation code.
REQ-015 illegal  out  1  the request was unsupported.
REQ-016 mc_busy  out  1  a multicycle operation is in progress.

Function
REQ-017 The block SHALL accept a request when in_valid && in_ready; in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-018 alu_op SHALL map as: 000->0x08 (ADDI), 001->0x00 (BEQZ), 010->0x23 (LW), 011->0x2B (SW), 100->decode, 101..111->dec_op 0x00 with illegal=1.
REQ-019 Decode with opcode!=0 SHALL pass opcode through unchanged, with illegal=0.
REQ-020 Decode with opcode==0 SHALL map funct as: 20->08, 24->0C, 25->0D, 28->18, 2C->1C, 04->14, 2A->1A, 29->19, 07->17, 06->16, 22->0A, 26->0E (hex), with illegal=0.
REQ-021 Decode with opcode==0 SHALL map funct 0x0E (MUL) to 0x3E and funct 0x0F (DIV) to 0x3F; both are multicycle.
REQ-022 Any other R-type funct SHALL produce dec_op 0x0E with illegal=1.
REQ-023 A single-cycle request accepted at edge N SHALL present out_valid=1 with its result after edge N (latency 1).
REQ-024 The FSM SHALL have two states, IDLE and BUSY; accepting MUL/DIV SHALL move IDLE->BUSY, load cnt with LAT-1, latch the code, and drive mc_busy=1.
REQ-025 In BUSY, cnt SHALL decrement each cycle; at cnt==0 the next edge SHALL set out_valid=1 and return to IDLE, so the result appears LAT cycles after acceptance.
REQ-026 Once out_valid=1, dec_op and illegal SHALL be held stable until out_valid && out_ready.
REQ-027 On the out_valid && out_ready edge, out_valid SHALL clear unless a new single-cycle request is accepted in the same cycle, in which case the new result SHALL replace the old one (back-to-back, no bubble).
REQ-028 flush=1 SHALL, at the next edge, clear out_valid, return the FSM to IDLE, zero cnt, and discard any request; flush SHALL take priority over every other event.
REQ-029 cnt SHALL be sized for max(MUL_LAT, DIV_LAT)-1 and SHALL never wrap.

Reset
REQ-030 rst=1 SHALL asynchronously force: state=IDLE, cnt=0, out_valid=0, dec_op=0, illegal=0, mc_busy=0.
REQ-031 Reset asserted during BUSY SHALL abandon the operation with no output produced.
REQ-032 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-033 All alu_op codes, funct codes, decoded op codes (including 0x3E/0x3F), and the state encoding SHALL reside in the shared package alu_ctrl_pkg.
REQ-034 The combinational table (REQ-018..022) SHALL be the sub-module alu_ctrl_decode, with outputs dec_op, illegal and is_multi; alu_ctrl_seq SHALL own the FSM, counter and handshake.

Verification
REQ-035 Case: alu_op=100, opcode=0, funct=0x22, out_ready=1 -> dec_op=0x0A, illegal=0, out_valid one cycle later.
REQ-036 Case: funct=0x0E (MUL), MUL_LAT=4 -> mc_busy high for 4 cycles, in_ready=0 during BUSY, dec_op=0x3E after exactly 4 cycles.
REQ-037 Case: out_ready=0 with out_valid=1 -> result held and in_ready=0; releasing out_ready while a new ADD is valid -> next result 0x08 with no bubble.
REQ-038 Case: funct=0x3F -> dec_op=0x0E, illegal=1; alu_op=110 -> dec_op=0x00, illegal=1.
REQ-039 Case: flush in cycle 2 of a DIV, and separately rst in cycle 2 of a DIV -> out_valid never asserts, mc_busy=0 next cycle, and in_ready=1 afterwards.
